packet_scheduler: RTL and testbench

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

---
 rtl/packet_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_packet_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/packet_scheduler.sv
// packet_scheduler
//   Chooses which HDMI data island packet goes into each available packet
//   slot. ACR, AVI InfoFrame and audio InfoFrame requests are held in
//   pending flags. Audio samples are issued whenever the sample FIFO has data.
//   An audio run counter keeps a steady sample stream from starving pending
//   InfoFrames.
//
//   Parameters
//     PACKET_CYCLES  pixel clocks one data island packet occupies
//     MAX_AUDIO_RUN  consecutive audio packets allowed while an InfoFrame waits
//
//   Ports
//     clk_pixel       sole clock, rising edge
//     reset           asynchronous, active-high
//     packet_slot     pulse: a packet slot is available
//     frame_start     pulse: start of video frame (requests AVI + audio InfoFrame)
//     acr_tick        pulse: request an audio clock regeneration packet
//     audio_ready     audio sample FIFO holds at least one sample
//     audio_pop       pulse: consume one FIFO sample (issued with type 0x02)
//     packet_load     pulse: packet_type valid, generators latch payload
//     packet_type     HDMI packet type of the most recent issue
//     acr_overrun     sticky: ACR requested while one was still pending
//     slot_collision  sticky: slot offered while the current packet was busy
//
//   Optional feature (macro PACKET_SCHEDULER_STATS_EN)
//     audio_sent, null_sent  saturating 16-bit counts of issued audio / null packets

module packet_scheduler #(
    parameter int PACKET_CYCLES = 32,
    parameter int MAX_AUDIO_RUN = 4
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       packet_slot,
    input  logic       frame_start,
    input  logic       acr_tick,
    input  logic       audio_ready,
    output logic       audio_pop,
    output logic       packet_load,
    output logic [7:0] packet_type,
    output logic       acr_overrun,
    output logic       slot_collision
`ifdef PACKET_SCHEDULER_STATS_EN
    ,
    output logic [15:0] audio_sent,
    output logic [15:0] null_sent
`endif
);

    localparam int CNT_W = (PACKET_CYCLES > 1) ? $clog2(PACKET_CYCLES) : 1;
    localparam int RUN_W = (MAX_AUDIO_RUN > 0) ? $clog2(MAX_AUDIO_RUN + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PACKET_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_AUDIO_RUN);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef enum logic [7:0] {
        PKT_NULL  = 8'h00,
        PKT_ACR   = 8'h01,
        PKT_AUDIO = 8'h02,
        PKT_AVI   = 8'h82,
        PKT_AINFO = 8'h84
    } pkt_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] busy_cnt, cnt_next;
    logic [RUN_W-1:0] audio_run;
    logic             acr_pend, avi_pend, ainfo_pend;

    logic             accept;
    pkt_t             sel;
    logic             acr_clr, avi_clr, ainfo_clr, audio_issue;

    // Slot acceptance, type selection and next state. Everything here reads
    // registered flags only, so a request arriving in the slot cycle waits
    // for the following slot.
    always_comb begin
        accept      = 1'b0;
        sel         = PKT_NULL;
        state_next  = state;
        cnt_next    = busy_cnt;
        acr_clr     = 1'b0;
        avi_clr     = 1'b0;
        ainfo_clr   = 1'b0;
        audio_issue = 1'b0;

        accept = packet_slot && ((state == IDLE) || (busy_cnt == '0));

        // Audio yields to a waiting InfoFrame once the run limit is reached.
        if (acr_pend)
            sel = PKT_ACR;
        else if (audio_ready && !((audio_run == RUN_MAX) && (avi_pend || ainfo_pend)))
            sel = PKT_AUDIO;
        else if (avi_pend)
            sel = PKT_AVI;
        else if (ainfo_pend)
            sel = PKT_AINFO;
        else
            sel = PKT_NULL;

        if (accept) begin
            acr_clr     = (sel == PKT_ACR);
            avi_clr     = (sel == PKT_AVI);
            ainfo_clr   = (sel == PKT_AINFO);
            audio_issue = (sel == PKT_AUDIO);
        end

        if (accept) begin
            state_next = BUSY;
            cnt_next   = CNT_LOAD;
        end else if (state == BUSY) begin
            if (busy_cnt == '0)
                state_next = IDLE;
            else
                cnt_next = busy_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy_cnt <= '0;
        end else begin
            state    <= state_next;
            busy_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            packet_load    <= 1'b0;
            audio_pop      <= 1'b0;
            packet_type    <= 8'h00;
            acr_pend       <= 1'b0;
            avi_pend       <= 1'b0;
            ainfo_pend     <= 1'b0;
            audio_run      <= '0;
            acr_overrun    <= 1'b0;
            slot_collision <= 1'b0;
        end else begin
            packet_load <= accept;
            audio_pop   <= audio_issue;
            if (accept)
                packet_type <= sel;

            // A request pulse coinciding with the clear keeps the flag set.
            acr_pend   <= acr_tick    | (acr_pend   & ~acr_clr);
            avi_pend   <= frame_start | (avi_pend   & ~avi_clr);
            ainfo_pend <= frame_start | (ainfo_pend & ~ainfo_clr);

            // Saturates at the limit so the comparison against RUN_MAX holds
            // for any run length.
            if (accept) begin
                if (audio_issue) begin
                    if (audio_run != RUN_MAX)
                        audio_run <= audio_run + RUN_W'(1);
                end else begin
                    audio_run <= '0;
                end
            end

            if (acr_tick && acr_pend && !acr_clr)
                acr_overrun <= 1'b1;
            if (packet_slot && !accept)
                slot_collision <= 1'b1;
        end
    end

`ifdef PACKET_SCHEDULER_STATS_EN
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            audio_sent <= '0;
            null_sent  <= '0;
        end else begin
            if (audio_issue && (audio_sent != '1))
                audio_sent <= audio_sent + 16'd1;
            if (accept && (sel == PKT_NULL) && (null_sent != '1))
                null_sent <= null_sent + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed testbench for packet_scheduler with default parameters
// (PACKET_CYCLES=32, MAX_AUDIO_RUN=4).

module tb_packet_scheduler;

    logic       clk_pixel;
    logic       reset;
    logic       packet_slot;
    logic       frame_start;
    logic       acr_tick;
    logic       audio_ready;
    logic       audio_pop;
    logic       packet_load;
    logic [7:0] packet_type;
    logic       acr_overrun;
    logic       slot_collision;
`ifdef PACKET_SCHEDULER_STATS_EN
    logic [15:0] audio_sent;
    logic [15:0] null_sent;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    packet_scheduler #(
        .PACKET_CYCLES(32),
        .MAX_AUDIO_RUN(4)
    ) dut (
        .clk_pixel     (clk_pixel),
        .reset         (reset),
        .packet_slot   (packet_slot),
        .frame_start   (frame_start),
        .acr_tick      (acr_tick),
        .audio_ready   (audio_ready),
        .audio_pop     (audio_pop),
        .packet_load   (packet_load),
        .packet_type   (packet_type),
        .acr_overrun   (acr_overrun),
        .slot_collision(slot_collision)
`ifdef PACKET_SCHEDULER_STATS_EN
        ,
        .audio_sent    (audio_sent),
        .null_sent     (null_sent)
`endif
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle request pulses, registered before any following slot.
    task automatic pulse_req(input logic a, input logic f);
        acr_tick    = a;
        frame_start = f;
        tick(1);
        acr_tick    = 1'b0;
        frame_start = 1'b0;
    endtask

    // Slot at cycle T, check the issue at T+1, then run to T+32 where the
    // next back-to-back slot is acceptable and no issue is in progress.
    task automatic issue(input string tag, input logic [7:0] t, input logic pop);
        packet_slot = 1'b1;
        tick(1);
        packet_slot = 1'b0;
        chk({tag, "_load"}, 16'(packet_load), 16'h1);
        chk({tag, "_type"}, 16'(packet_type), 16'(t));
        chk({tag, "_pop"},  16'(audio_pop),   16'(pop));
        tick(31);
        chk({tag, "_quiet"}, 16'({packet_load, audio_pop}), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        packet_slot = 1'b0;
        frame_start = 1'b0;
        acr_tick    = 1'b0;
        audio_ready = 1'b0;
        tick(3);
        chk("rst_load", 16'(packet_load),    16'h0);
        chk("rst_pop",  16'(audio_pop),      16'h0);
        chk("rst_type", 16'(packet_type),    16'h00);
        chk("rst_ovr",  16'(acr_overrun),    16'h0);
        chk("rst_col",  16'(slot_collision), 16'h0);
        reset = 1'b0;
        tick(2);

        // Single slot without requests -> null packet.
        issue("null1", 8'h00, 1'b0);

        // ACR first, four audio samples, then the waiting AVI beats audio,
        // audio InfoFrame once samples stop, then null.
        audio_ready = 1'b1;
        pulse_req(1'b1, 1'b1);
        issue("pri_acr",  8'h01, 1'b0);
        issue("pri_aud1", 8'h02, 1'b1);
        issue("pri_aud2", 8'h02, 1'b1);
        issue("pri_aud3", 8'h02, 1'b1);
        issue("pri_aud4", 8'h02, 1'b1);
        issue("pri_avi",  8'h82, 1'b0);
        audio_ready = 1'b0;
        issue("pri_ainf", 8'h84, 1'b0);
        issue("pri_null", 8'h00, 1'b0);
        chk("pri_ovr", 16'(acr_overrun), 16'h0);

        // Two ACR requests without a slot between them.
        pulse_req(1'b1, 1'b0);
        chk("ovr_before", 16'(acr_overrun), 16'h0);
        pulse_req(1'b1, 1'b0);
        chk("ovr_after", 16'(acr_overrun), 16'h1);
        issue("ovr_acr",  8'h01, 1'b0);
        issue("ovr_null", 8'h00, 1'b0);

        // Slot at T accepted, slot at T+10 ignored, slot at T+32 accepted.
        chk("col_before", 16'(slot_collision), 16'h0);
        packet_slot = 1'b1;
        tick(1);
        packet_slot = 1'b0;
        chk("col_first_load", 16'(packet_load), 16'h1);
        tick(9);
        packet_slot = 1'b1;
        tick(1);
        packet_slot = 1'b0;
        chk("col_ign_load", 16'(packet_load),    16'h0);
        chk("col_flag",     16'(slot_collision), 16'h1);
        tick(21);
        issue("col_t32", 8'h00, 1'b0);

        // frame_start in the AVI issue cycle re-arms both InfoFrames.
        pulse_req(1'b0, 1'b1);
        frame_start = 1'b1;
        packet_slot = 1'b1;
        tick(1);
        packet_slot = 1'b0;
        frame_start = 1'b0;
        chk("fs_avi1_load", 16'(packet_load), 16'h1);
        chk("fs_avi1_type", 16'(packet_type), 16'h82);
        tick(31);
        issue("fs_avi2", 8'h82, 1'b0);
        issue("fs_ainf", 8'h84, 1'b0);
        issue("fs_null", 8'h00, 1'b0);

        // Reset at T+5 of an ACR packet with an AVI still pending.
        pulse_req(1'b1, 1'b1);
        packet_slot = 1'b1;
        tick(1);
        packet_slot = 1'b0;
        chk("mid_type", 16'(packet_type), 16'h01);
        tick(4);
        reset = 1'b1;
        #1;
        chk("mid_rst_load", 16'(packet_load),    16'h0);
        chk("mid_rst_pop",  16'(audio_pop),      16'h0);
        chk("mid_rst_type", 16'(packet_type),    16'h00);
        chk("mid_rst_ovr",  16'(acr_overrun),    16'h0);
        chk("mid_rst_col",  16'(slot_collision), 16'h0);
        tick(2);
        reset = 1'b0;
        tick(1);
        issue("post_rst", 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
